// File: rtl/reg_writeback_if.sv
// Bundle of issue, hazard-query, result and register-file write signals
// around the writeback stage. Signal names match the register-file side ports.
interface reg_writeback_if #(
  parameter int RegWidth = 32,
  parameter int RegDepth = 32
);
  localparam int AW = $clog2(RegDepth);

  logic                issue_valid_i;
  logic [AW-1:0]       issue_rd_i;
  logic                issue_ready_o;

  logic [AW-1:0]       rs1_addr_i;
  logic [AW-1:0]       rs2_addr_i;
  logic                rs1_busy_o;
  logic                rs2_busy_o;

  logic                alu_valid_i;
  logic [AW-1:0]       alu_rd_i;
  logic [RegWidth-1:0] alu_data_i;
  logic                alu_ready_o;

  logic                lsu_valid_i;
  logic [AW-1:0]       lsu_rd_i;
  logic [RegWidth-1:0] lsu_data_i;
  logic                lsu_ready_o;

  logic [AW-1:0]       rd_addr_o;
  logic [RegWidth-1:0] rd_data_o;
  logic                rd_write_en_o;

  // Issue logic and execute units side.
  modport master (
    output issue_valid_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
           alu_valid_i, alu_rd_i, alu_data_i,
           lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  issue_ready_o, rs1_busy_o, rs2_busy_o, alu_ready_o, lsu_ready_o,
           rd_addr_o, rd_data_o, rd_write_en_o
  );

  // Writeback stage side.
  modport slave (
    input  issue_valid_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
           alu_valid_i, alu_rd_i, alu_data_i,
           lsu_valid_i, lsu_rd_i, lsu_data_i,
    output issue_ready_o, rs1_busy_o, rs2_busy_o, alu_ready_o, lsu_ready_o,
           rd_addr_o, rd_data_o, rd_write_en_o
  );
endinterface

// File: rtl/reg_writeback.sv
// Writeback stage: round-robin ALU/LSU arbitration into a registered single
// register-file write port, plus a pending-write scoreboard for RAW/WAW stalls.
module reg_writeback #(
  parameter int RegWidth = 32,
  parameter int RegDepth = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  reg_writeback_if.slave bus
);
  localparam int AW = $clog2(RegDepth);

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_LSU = 1'b1
  } prio_e;

  prio_e               prio_q, prio_d;
  logic [RegDepth-1:0] busy_q, busy_d;
  logic                alu_grant, lsu_grant, issue_fire;
  logic [AW-1:0]       rd_addr_q;
  logic [RegWidth-1:0] rd_data_q;
  logic                rd_we_q;

  // Bit 0 of busy_q is held at zero so x0 never reads as pending.
  assign bus.rs1_busy_o    = (bus.rs1_addr_i != '0) && busy_q[bus.rs1_addr_i];
  assign bus.rs2_busy_o    = (bus.rs2_addr_i != '0) && busy_q[bus.rs2_addr_i];
  assign bus.issue_ready_o = (bus.issue_rd_i == '0) || !busy_q[bus.issue_rd_i];
  assign issue_fire        = bus.issue_valid_i && bus.issue_ready_o;

  assign alu_grant = bus.alu_valid_i && (!bus.lsu_valid_i || prio_q == PRIO_ALU);
  assign lsu_grant = bus.lsu_valid_i && !alu_grant;

  assign bus.alu_ready_o = alu_grant;
  assign bus.lsu_ready_o = lsu_grant;

  assign bus.rd_addr_o     = rd_addr_q;
  assign bus.rd_data_o     = rd_data_q;
  assign bus.rd_write_en_o = rd_we_q;

  always_comb begin
    // NOTE: every signal gets its default first so no path can infer a latch.
    busy_d = busy_q;
    prio_d = prio_q;
    if (rd_we_q) busy_d[rd_addr_q] = 1'b0;
    // Clear before set: a same-register collision is excluded by issue_ready.
    if (issue_fire && bus.issue_rd_i != '0) busy_d[bus.issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
    if (bus.alu_valid_i && bus.lsu_valid_i)
      prio_d = (prio_q == PRIO_ALU) ? PRIO_LSU : PRIO_ALU;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is assigned non-blocking so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      busy_q <= '0;
      prio_q <= PRIO_ALU;
    end else begin
      busy_q <= busy_d;
      prio_q <= prio_d;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: address and data are reset too (not just the enable) so the
    // write port shows a known, quiet value straight out of reset.
    if (rst_i) begin
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (alu_grant) begin
      rd_we_q   <= (bus.alu_rd_i != '0);
      rd_addr_q <= bus.alu_rd_i;
      rd_data_q <= bus.alu_data_i;
    end else if (lsu_grant) begin
      rd_we_q   <= (bus.lsu_rd_i != '0);
      rd_addr_q <= bus.lsu_rd_i;
      rd_data_q <= bus.lsu_data_i;
    end else begin
      rd_we_q   <= 1'b0;
    end
  end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage and pending-write scoreboard for the integer register file. It arbitrates results from the ALU and the load/store unit and drives the register file's single write port. It also tracks which destination registers have an issued-but-uncommitted write, so issue logic can stall on RAW and WAW hazards. It sits between the execute units and the register file, as the write-side counterpart of the register file read ports.

## Interface
- RegWidth, 32, data width of one register
- RegDepth, 32, number of architectural registers; AW = $clog2(RegDepth)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- issue_valid_i  in  1  issue stage wants to dispatch an instruction that writes issue_rd_i
- issue_rd_i  in  AW  destination of the issuing instruction
- issue_ready_o  out  1  dispatch accepted this cycle
- rs1_addr_i, rs2_addr_i  in  AW  source registers to check
- rs1_busy_o, rs2_busy_o  out  1  source has a pending write
- alu_valid_i, lsu_valid_i  in  1  result offered by the ALU or the LSU
- alu_rd_i, lsu_rd_i  in  AW  result destination
- alu_data_i, lsu_data_i  in  RegWidth  result value
- alu_ready_o, lsu_ready_o  out  1  result accepted this cycle
- rd_addr_o  out  AW  to register file rd_addr_i
- rd_data_o  out  RegWidth  to register file rd_data_i
- rd_write_en_o  out  1  to register file rd_write_en_i

## Operation
- **Scoreboard state:** busy_q[RegDepth-1:1], one bit per register; x0 has no bit and is never busy.
- **Busy outputs:** rsN_busy_o = (rsN_addr_i != 0) && busy_q[rsN_addr_i]. This path is combinational.
- **Issue:** issue_ready_o = (issue_rd_i == 0) || !busy_q[issue_rd_i]. It is independent of issue_valid_i. A WAW stall holds ready low until the pending write commits.
- **Issue accept:** occurs when issue_valid_i && issue_ready_o. If issue_rd_i != 0, busy_q[issue_rd_i] is set at the clock edge.
- **Arbitration:** round-robin between ALU and LSU, with pointer prio_q (0 = ALU preferred).
  - Only one source valid: grant it; prio_q unchanged.
  - Both valid: grant the preferred source and toggle prio_q.
  - Neither valid: no grant.
- **Result ready:** alu_ready_o and lsu_ready_o are high only for the granted source. They may depend combinationally on the valids. At most one is high per cycle.
- **Output register:** on a grant, rd_addr_o and rd_data_o load the granted rd and data at the edge. rd_write_en_o loads (granted rd != 0). Without a grant, rd_write_en_o loads 0 and rd_addr_o/rd_data_o hold their values.
- **Commit:** the register file captures the write at the edge that ends the cycle in which rd_write_en_o = 1. busy_q[rd_addr_o] is cleared on that same edge.
- **Same-register conflict:** an issue set and a commit clear cannot target the same register in one cycle, because issue_ready_o is low while that bit is set. Set and clear of different registers in the same cycle both take effect.
- **Result for a non-busy rd:** this is a protocol violation, but the result is still written and the scoreboard is unchanged.
- **Reset:**
  - busy_q = 0, prio_q = 0.
  - rd_write_en_o = 0, rd_addr_o = 0, rd_data_o = 0.
  - An in-flight result held in the output register is discarded (no write occurs).
  - Reset overrides any same-cycle issue accept or grant.

## Timing
- **Result-to-write latency:** 1 cycle. A result accepted in cycle N appears on rd_* in cycle N+1 and is committed at the end of N+1.
- **Register readability:** in cycle N+2 the register file holds the data and rsN_busy_o is 0 for that register.
- **Throughput:** one result per cycle. The write port never backpressures.
- **Issue-to-busy latency:** an issue accepted in cycle N shows busy in cycle N+1.
- **Combinational paths:** issue_ready_o, rsN_busy_o and the result readies depend on current inputs and state only. There are no combinational paths from the result inputs to rd_*.

## Test plan
- **Reset:** assert rst_i for 2 cycles with all valids high → rd_write_en_o = 0, rd_addr_o = 0, rd_data_o = 0, both busy outputs 0; first grant after release goes to the ALU.
- **Single write, full lifecycle:**
  - Issue rd=5 → rs1_addr_i=5 gives rs1_busy_o=1 next cycle.
  - A second issue of rd=5 → issue_ready_o=0.
  - ALU result rd=5, data 0xDEADBEEF → next cycle rd_write_en_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF.
  - Cycle after that → rs1_busy_o=0, issue_ready_o=1 for rd=5.
- **Round-robin fairness:** ALU and LSU both valid for 4 cycles (ALU rd=1..4, LSU rd=9..12) → writes committed in order 1, 9, 2, 10; alu_ready_o and lsu_ready_o never both high.
- **x0 handling:** issue rd=0 → issue_ready_o=1, no busy bit set; LSU result rd=0, data 0x1234 → lsu_ready_o=1, rd_write_en_o stays 0.
- **Simultaneous events:** commit of rd=7 in the same cycle as an issue of rd=3 → next cycle busy[3]=1 and busy[7]=0.
- **Reset mid-flight:** ALU result rd=8 accepted in cycle N, rst_i high in cycle N → rd_write_en_o=0 in N+1, busy[8]=0, no write reaches the register file.
